// File: rtl/mux_base.sv
// -----------------------------------------------------------------------------
// mux_base
//   Parameterizable 2^SEL_WIDTH-to-1 single-bit multiplexer built as a
//   balanced binary tree of 2:1 AND-OR cells (SEL_WIDTH levels). Level 0 pairs
//   in[2j+1]/in[2j] under sel[0]; each following level pairs the previous
//   level's results under the next select bit.
//
//   The combinational output is independent of clk/reset, so shifter stages
//   may leave those pins unconnected. out_q is a registered copy of out for
//   pipelined users.
//
// Ports
//   clk    in   1            rising-edge clock (out_q only)
//   reset  in   1            synchronous active-high clear (out_q only)
//   sel    in   SEL_WIDTH    index of the data bit to pass
//   in     in   2**SEL_WIDTH data bits; bit k selected when sel == k
//   out    out  1            combinational in[sel]
//   out_q  out  1            out delayed by one clk edge, 0 after reset
// -----------------------------------------------------------------------------
module mux_base #(
  parameter int SEL_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic [(2**SEL_WIDTH)-1:0] in,
  output logic                      out,
  output logic                      out_q
);

  localparam int N = 2 ** SEL_WIDTH;

  if (SEL_WIDTH < 1 || SEL_WIDTH > 6) begin : g_bad_width
    $error("mux_base: SEL_WIDTH=%0d outside legal range 1..6", SEL_WIDTH);
  end

  logic r_out_q;

  for (genvar l = 0; l < SEL_WIDTH; l++) begin : g_lvl
    localparam int N_OUT = N >> (l + 1);

    logic [2*N_OUT-1:0] w_src;
    logic [N_OUT-1:0]   w_lvl;

    if (l == 0) begin : g_first
      assign w_src = in;
    end else begin : g_next
      assign w_src = g_lvl[l-1].w_lvl;
    end

    // AND-OR form keeps an X on the unselected leg from reaching the output
    // whenever the select bit is known.
    for (genvar j = 0; j < N_OUT; j++) begin : g_cell
      assign w_lvl[j] = (sel[l] & w_src[2*j+1]) | (~sel[l] & w_src[2*j]);
    end
  end

  assign out = g_lvl[SEL_WIDTH-1].w_lvl[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= out;
    end
  end

  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_base.sv
module tb_mux_base;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: select is just "bit sel of the data word".
  function automatic logic ref_mux(input logic [63:0] data, input int idx);
    return (data >> idx) & 64'd1;
  endfunction

  // SEL_WIDTH = 1, fully wired (combinational and registered path)
  logic       reset;
  logic       s1_sel;
  logic [1:0] s1_in;
  logic       s1_out, s1_q;

  mux_base #(.SEL_WIDTH(1)) u_dut (
    .clk(clk), .reset(reset), .sel(s1_sel), .in(s1_in), .out(s1_out), .out_q(s1_q)
  );

  // SEL_WIDTH = 1 with clock/reset tied off, as in the shifter stages
  logic       u_sel;
  logic [1:0] u_in;
  logic       u_out, u_q;

  mux_base #(.SEL_WIDTH(1)) u_noclk (
    .clk(1'b0), .reset(1'b0), .sel(u_sel), .in(u_in), .out(u_out), .out_q(u_q)
  );

  logic [1:0] s2_sel;
  logic [3:0] s2_in;
  logic       s2_out, s2_q;
  mux_base #(.SEL_WIDTH(2)) u_w2 (
    .clk(clk), .reset(reset), .sel(s2_sel), .in(s2_in), .out(s2_out), .out_q(s2_q)
  );

  logic [2:0] s3_sel;
  logic [7:0] s3_in;
  logic       s3_out, s3_q;
  mux_base #(.SEL_WIDTH(3)) u_w3 (
    .clk(clk), .reset(reset), .sel(s3_sel), .in(s3_in), .out(s3_out), .out_q(s3_q)
  );

  logic [5:0]  s6_sel;
  logic [63:0] s6_in;
  logic        s6_out, s6_q;
  mux_base #(.SEL_WIDTH(6)) u_w6 (
    .clk(clk), .reset(reset), .sel(s6_sel), .in(s6_in), .out(s6_out), .out_q(s6_q)
  );

  // 4-bit fixed shifter, SHAMT = 1; top bit shifts in a constant 0
  logic       sh_shift;
  logic [3:0] sh_in;
  logic [3:0] sh_out, sh_q;
  logic [4:0] sh_ext;
  assign sh_ext = {1'b0, sh_in};

  for (genvar i = 0; i < 4; i++) begin : g_sh
    mux_base #(.SEL_WIDTH(1)) u_sh (
      .clk(1'b0), .reset(1'b0), .sel(sh_shift), .in(sh_ext[i+1:i]),
      .out(sh_out[i]), .out_q(sh_q[i])
    );
  end

  logic exp_q;

  initial begin
    reset = 1'b1; s1_sel = 1'b0; s1_in = 2'b00;
    u_sel = 1'b0; u_in = 2'b00;
    s2_sel = '0; s2_in = '0; s3_sel = '0; s3_in = '0; s6_sel = '0; s6_in = '0;
    sh_shift = 1'b0; sh_in = 4'b0000;

    // Test 1: basic select ordering, unclocked instance
    begin
      logic [1:0] pats [2];
      pats[0] = 2'b10; pats[1] = 2'b01;
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < 2; s++) begin
          u_in = pats[p]; u_sel = s[0];
          #1 chk("t1_noclk", {63'd0, u_out}, {63'd0, ref_mux({62'd0, pats[p]}, s)});
        end
      end
    end

    // Test 2: shifter follows the shift sequence 0,1,1,0,1
    begin
      logic seq [5];
      seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b1; seq[3] = 1'b0; seq[4] = 1'b1;
      sh_in = 4'b1000;
      for (int k = 0; k < 5; k++) begin
        sh_shift = seq[k];
        #1 chk("t2_shift", {60'd0, sh_out}, seq[k] ? 64'(sh_in >> 1) : 64'(sh_in));
      end
      repeat (10) begin
        sh_in = 4'($urandom); sh_shift = 1'($urandom);
        #1 chk("t2_shift_rnd", {60'd0, sh_out}, sh_shift ? 64'(sh_in >> 1) : 64'(sh_in));
      end
    end

    // Test 3: SEL_WIDTH=3 sweep of 8'b1010_0110 -> 0,1,1,0,0,1,0,1
    begin
      logic [7:0] want;
      want = 8'b1010_0110;
      s3_in = 8'b1010_0110;
      for (int s = 0; s < 8; s++) begin
        s3_sel = 3'(s);
        #1 chk("t3_sweep", {63'd0, s3_out}, {63'd0, want[s]});
      end
    end

    // Constant data: all-zero and all-one for every sel (SEL_WIDTH=3)
    for (int c = 0; c < 2; c++) begin
      s3_in = (c == 0) ? 8'h00 : 8'hFF;
      for (int s = 0; s < 8; s++) begin
        s3_sel = 3'(s);
        #1 chk("const_data", {63'd0, s3_out}, 64'(c));
      end
    end

    // Test 4: registered path
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("t4_reset_hold", {63'd0, s1_q}, 64'd0);
    @(negedge clk); reset = 1'b0; s1_in = 2'b11; s1_sel = 1'b1;
    @(posedge clk); #1 chk("t4_track", {63'd0, s1_q}, 64'd1);
    @(negedge clk); reset = 1'b1;
    #1 chk("t4_out_ignores_reset", {63'd0, s1_out}, 64'd1);
    @(posedge clk); #1 chk("t4_mid_reset", {63'd0, s1_q}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 chk("t4_resume", {63'd0, s1_q}, 64'd1);

    // Test 5a: X on unselected data bit
    u_in = 2'bx1; u_sel = 1'b0;
    #1 chk("t5_xiso", {63'd0, u_out}, 64'd1);
    s1_in = 2'bx0; s1_sel = 1'b0;
    #1 chk("t5_xiso0", {63'd0, s1_out}, 64'd0);

    // Test 5b: exhaustive SEL_WIDTH=2
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        s2_in = 4'(d); s2_sel = 2'(s);
        #1 chk("t5_exh_w2", {63'd0, s2_out}, {63'd0, ref_mux(64'(d), s)});
      end
    end

    // Max sel picks MSB on the widest instance
    s6_in = 64'h8000_0000_0000_0000; s6_sel = 6'd63;
    #1 chk("w6_msb", {63'd0, s6_out}, 64'd1);
    s6_in = ~64'h8000_0000_0000_0000;
    #1 chk("w6_msb0", {63'd0, s6_out}, 64'd0);

    // Randomized: sel and data change together; out_q follows one edge later
    repeat (300) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 9) == 0);
      s1_in  = 2'($urandom); s1_sel = 1'($urandom);
      s3_in  = 8'($urandom); s3_sel = 3'($urandom);
      s6_in  = {$urandom, $urandom}; s6_sel = 6'($urandom);
      #1;
      chk("rnd_w1", {63'd0, s1_out}, {63'd0, ref_mux({62'd0, s1_in}, int'(s1_sel))});
      chk("rnd_w3", {63'd0, s3_out}, {63'd0, ref_mux({56'd0, s3_in}, int'(s3_sel))});
      chk("rnd_w6", {63'd0, s6_out}, {63'd0, ref_mux(s6_in, int'(s6_sel))});
      exp_q = reset ? 1'b0 : ref_mux({62'd0, s1_in}, int'(s1_sel));
      @(posedge clk); #1;
      chk("rnd_q_w1", {63'd0, s1_q}, {63'd0, exp_q});
      chk("rnd_q_w6", {63'd0, s6_q}, reset ? 64'd0 : {63'd0, ref_mux(s6_in, int'(s6_sel))});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
